// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: recovers hex digits from a multiplexed active-low
// 7-segment bus. Each (anode, segment) pair must be stable for STABLE_CYC
// samples before it is decoded into a per-slot register file. Every capture
// is also reported as a single-entry valid/ready event.
module seg7_capture_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [6:0]        i_seg,
  input  logic [NDIG-1:0]   i_an,
  output logic [4*NDIG-1:0] o_digits,
  output logic [NDIG-1:0]   o_vmask,
  output logic [NDIG-1:0]   o_emask,
  output logic              o_evt_valid,
  input  logic              i_evt_ready,
  output logic [2:0]        o_evt_idx,
  output logic [3:0]        o_evt_dig,
  output logic              o_evt_err,
  output logic              o_ovf
);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  // Capture fires on the edge where the count would reach STABLE_CYC.
  localparam logic [7:0] CAP_AT = 8'(STABLE_CYC - 1);
  localparam logic [7:0] CNT_HELD = 8'(STABLE_CYC);

  state_t          state, state_n;
  logic [7:0]      cnt, cnt_n;
  logic [6:0]      p_seg, trk_seg;
  logic [NDIG-1:0] p_an, trk_an;
  logic            trk_ld, cap;
  logic [3:0]      low_cnt;
  logic [2:0]      slot;
  logic            cand, same;
  logic [4:0]      dec;   // {recognised, nibble}

  // Active-low segment pattern to {ok, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = {1'b1, 4'h0};
      7'h79: seg_decode = {1'b1, 4'h1};
      7'h24: seg_decode = {1'b1, 4'h2};
      7'h30: seg_decode = {1'b1, 4'h3};
      7'h19: seg_decode = {1'b1, 4'h4};
      7'h12: seg_decode = {1'b1, 4'h5};
      7'h02: seg_decode = {1'b1, 4'h6};
      7'h78: seg_decode = {1'b1, 4'h7};
      7'h00: seg_decode = {1'b1, 4'h8};
      7'h18: seg_decode = {1'b1, 4'h9};
      7'h08: seg_decode = {1'b1, 4'hA};
      7'h03: seg_decode = {1'b1, 4'hB};
      7'h46: seg_decode = {1'b1, 4'hC};
      7'h21: seg_decode = {1'b1, 4'hD};
      7'h06: seg_decode = {1'b1, 4'hE};
      7'h0E: seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'h00;
    endcase
  endfunction

  // Single input sample stage; all decisions are made on p.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_seg <= '0;
      p_an  <= '0;
    end else begin
      p_seg <= i_seg;
      p_an  <= i_an;
    end
  end

  // Slot qualification: exactly one low anode bit, and its position.
  always_comb begin
    low_cnt = '0;
    slot    = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!p_an[i]) begin
        low_cnt = low_cnt + 4'd1;
        slot    = 3'(i);
      end
    end
  end

  assign cand = (low_cnt == 4'd1);
  assign same = (p_seg == trk_seg) && (p_an == trk_an);
  assign dec  = seg_decode(p_seg);

  // Stability tracker next-state logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    trk_ld  = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (cand) begin
          state_n = TRACK;
          cnt_n   = 8'd1;
          trk_ld  = 1'b1;
        end
      end
      TRACK: begin
        if (!cand) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!same) begin
          cnt_n  = 8'd1;
          trk_ld = 1'b1;
        end else if (cnt == CAP_AT) begin
          cap     = 1'b1;
          state_n = HELD;
          cnt_n   = CNT_HELD;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!cand) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!same) begin
          state_n = TRACK;
          cnt_n   = 8'd1;
          trk_ld  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Tracker state, count and the pattern being tracked.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      trk_seg <= '0;
      trk_an  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (trk_ld) begin
        trk_seg <= p_seg;
        trk_an  <= p_an;
      end
    end
  end

  // Per-slot register file; error captures keep the last good nibble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_digits <= '0;
      o_vmask  <= '0;
      o_emask  <= '0;
    end else if (cap) begin
      for (int k = 0; k < NDIG; k++) begin
        if (int'(slot) == k) begin
          if (dec[4]) begin
            o_digits[4*k +: 4] <= dec[3:0];
            o_vmask[k]         <= 1'b1;
            o_emask[k]         <= 1'b0;
          end else begin
            o_emask[k] <= 1'b1;
          end
        end
      end
    end
  end

  // One-entry event buffer: loads when empty or draining, else drops and flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_evt_valid <= 1'b0;
      o_evt_idx   <= '0;
      o_evt_dig   <= '0;
      o_evt_err   <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (cap) begin
      if (o_evt_valid && !i_evt_ready) begin
        o_ovf <= 1'b1;
      end else begin
        o_evt_valid <= 1'b1;
        o_evt_idx   <= slot;
        o_evt_dig   <= dec[4] ? dec[3:0] : 4'h0;
        o_evt_err   <= !dec[4];
      end
    end else if (o_evt_valid && i_evt_ready) begin
      o_evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed scenarios plus random traffic,
// checked against a run-length reference model and an event scoreboard.
module tb_seg7_capture_decoder;
  localparam int NDIG = 4;
  localparam int S    = 4;

  logic            i_clk = 0;
  logic            i_rst = 1;
  logic [6:0]      i_seg = 7'h7F;
  logic [NDIG-1:0] i_an  = '1;
  logic            i_evt_ready = 0;
  logic [4*NDIG-1:0] o_digits;
  logic [NDIG-1:0] o_vmask, o_emask;
  logic            o_evt_valid, o_evt_err, o_ovf;
  logic [2:0]      o_evt_idx;
  logic [3:0]      o_evt_dig;

  seg7_capture_decoder #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_seg(i_seg), .i_an(i_an),
    .o_digits(o_digits), .o_vmask(o_vmask), .o_emask(o_emask),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
    .o_evt_idx(o_evt_idx), .o_evt_dig(o_evt_dig), .o_evt_err(o_evt_err),
    .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference glyph table: index is the nibble.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed { logic [2:0] idx; logic [3:0] dig; logic err; } evt_t;

  // Model state
  logic [15:0]     m_digits = '0;
  logic [NDIG-1:0] m_vmask = '0, m_emask = '0;
  logic            m_valid = 0, m_ovf = 0;
  evt_t            m_cur = '0;
  evt_t            expq[$];
  int              run = 0;
  logic [NDIG-1:0] last_an = '0;
  logic [6:0]      last_seg = '0;
  logic            sched = 0;
  int              sched_slot = 0;
  logic [6:0]      sched_seg = '0;

  // Reference model: a capture is due one edge after the S-th consecutive
  // identical single-slot sample.
  initial forever begin
    @(posedge i_clk or posedge i_rst);
    if (i_rst) begin
      m_digits = '0; m_vmask = '0; m_emask = '0; m_valid = 0; m_ovf = 0;
      m_cur = '0; expq.delete(); run = 0; sched = 0;
      last_an = '0; last_seg = '0;
    end else begin
      if (sched) begin
        int nib;
        evt_t e;
        nib = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == sched_seg) nib = g;
        if (nib >= 0) begin
          m_digits[4*sched_slot +: 4] = 4'(nib);
          m_vmask[sched_slot] = 1'b1;
          m_emask[sched_slot] = 1'b0;
        end else begin
          m_emask[sched_slot] = 1'b1;
        end
        e.idx = 3'(sched_slot);
        e.dig = (nib >= 0) ? 4'(nib) : 4'h0;
        e.err = (nib < 0);
        if (m_valid && !i_evt_ready) m_ovf = 1;
        else begin
          m_valid = 1; m_cur = e; expq.push_back(e);
        end
      end else if (m_valid && i_evt_ready) begin
        m_valid = 0;
      end
      sched = 0;
      if ($countones(~i_an) != 1) run = 0;
      else if (run > 0 && i_an == last_an && i_seg == last_seg) run = (run > S) ? run : run + 1;
      else run = 1;
      last_an = i_an; last_seg = i_seg;
      if (run == S) begin
        sched = 1;
        sched_seg = i_seg;
        for (int k = 0; k < NDIG; k++) if (!i_an[k]) sched_slot = k;
      end
    end
  end

  // Monitor: register state every cycle; events popped on each transfer.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("digits", 32'(o_digits), 32'(m_digits));
      chk("vmask", 32'(o_vmask), 32'(m_vmask));
      chk("emask", 32'(o_emask), 32'(m_emask));
      chk("ovf", 32'(o_ovf), 32'(m_ovf));
      chk("evt_valid", 32'(o_evt_valid), 32'(m_valid));
      if (o_evt_valid && m_valid)
        chk("evt_hold", 32'({o_evt_idx, o_evt_dig, o_evt_err}), 32'(m_cur));
      if (o_evt_valid && i_evt_ready) begin
        if (expq.size() == 0) chk("evt_unexpected", 32'(1), 32'(0));
        else begin
          evt_t e;
          e = expq.pop_front();
          chk("evt_xfer", 32'({o_evt_idx, o_evt_dig, o_evt_err}), 32'(e));
        end
      end
    end
  end

  // Hold inputs for n edges; ready either fixed or randomised per cycle.
  task automatic hold(input logic [NDIG-1:0] an, input logic [6:0] seg,
                      input int rdy, input int n);
    i_an = an; i_seg = seg;
    repeat (n) begin
      i_evt_ready = (rdy > 1) ? 1'($urandom_range(0, 1)) : 1'(rdy);
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1 chk("rst_digits", 32'(o_digits), 32'(0));
    chk("rst_flags", 32'({o_vmask, o_emask, o_evt_valid, o_ovf}), 32'(0));
    i_rst = 0;

    hold(4'b1011, 7'h24, 1, 8);                 // valid capture slot 2
    chk("valid_dig2", 32'(o_digits[11:8]), 32'h2);
    hold(4'b1110, 7'h40, 1, 6);                 // full scan
    hold(4'b1101, 7'h79, 1, 6);
    hold(4'b1011, 7'h0E, 1, 6);
    hold(4'b0111, 7'h03, 1, 6);
    hold(4'b1111, 7'h7F, 1, 2);
    chk("scan_digits", 32'(o_digits), 32'hBF10);
    chk("scan_vmask", 32'(o_vmask), 32'hF);
    hold(4'b1101, 7'h12, 1, 2);                 // glitch rejection
    hold(4'b1101, 7'h13, 1, 1);
    hold(4'b1101, 7'h12, 1, 6);
    chk("glitch_dig", 32'(o_digits[7:4]), 32'h5);
    hold(4'b0111, 7'h18, 1, 6);                 // slot 3 holds 9
    hold(4'b0111, 7'h7F, 1, 6);                 // error capture
    chk("err_emask3", 32'(o_emask[3]), 32'h1);
    chk("err_keep9", 32'(o_digits[15:12]), 32'h9);
    hold(4'b1110, 7'h24, 0, 6);                 // overflow
    hold(4'b1101, 7'h30, 0, 6);
    chk("ovf_flag", 32'(o_ovf), 32'h1);
    hold(4'b1101, 7'h30, 1, 3);
    hold(4'b0011, 7'h24, 1, 20);                // multiple low anodes
    hold(4'b1110, 7'h19, 1, 2);                 // reset mid-track
    #2 i_rst = 1;
    #1 chk("rst_async", 32'({o_digits, o_vmask, o_emask, o_evt_valid, o_evt_idx,
                             o_evt_dig, o_evt_err, o_ovf}), 32'(0));
    @(posedge i_clk); #1 i_rst = 0;
    hold(4'b1110, 7'h19, 1, 6);

    for (int it = 0; it < 300; it++) begin      // random traffic
      logic [NDIG-1:0] an;
      logic [6:0] seg;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin an = '1; an[$urandom_range(0, NDIG-1)] = 1'b0; end
      else if (r < 8) an = '1;
      else an = NDIG'($urandom);
      seg = ($urandom_range(0, 5) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      hold(an, seg, 2, $urandom_range(1, 8));
    end

    i_an = '1; i_evt_ready = 1;
    for (int w = 0; w < 20 && o_evt_valid; w++) begin @(posedge i_clk); #1; end
    chk("drain_valid", 32'(o_evt_valid), 32'(0));
    chk("drain_queue", 32'(expq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
